// File: rtl/nios2_jtag_debug_scan_master_if.sv
// Bundle of command/response handshakes and virtual-JTAG strobes for the
// Nios II debug scan master; "master" is the scan-master side, "slave" the requester/TAP side.
`timescale 1ns/1ps
interface nios2_jtag_debug_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
) ();
    // Handshakes: a word moves on a clk edge where valid && ready are both high;
    // valid may not depend on ready, and the sender holds its payload stable while valid.
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_dr;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DR_WIDTH-1:0] rsp_data;
    logic                vji_tck;
    logic                vji_tdi;
    logic                vji_tdo;
    logic [IR_WIDTH-1:0] vji_ir_in;
    logic                vji_uir;
    logic                vji_cdr;
    logic                vji_sdr;
    logic                vji_udr;
    logic                vji_rti;
    logic [2:0]          dbg_state;

    modport master (
        input  cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo,
        output cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, dbg_state
    );

    modport slave (
        output cmd_valid, cmd_ir, cmd_dr, rsp_ready, vji_tdo,
        input  cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
               vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti, dbg_state
    );
endinterface

// File: rtl/nios2_jtag_debug_scan_master.sv
// Runs one IR/DR virtual-JTAG scan per command with a divided tck and returns the tdo capture.
// Optional IR cache (skip UIR on a repeated IR): define NIOS2_JTAG_SCAN_IR_CACHE_EN.
`timescale 1ns/1ps
module nios2_jtag_debug_scan_master #(
    parameter int DR_WIDTH   = 38,
    parameter int IR_WIDTH   = 2,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 1
) (
    input logic clk,
    input logic reset,
    nios2_jtag_debug_scan_master_if.master bus
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int BIT_W = $clog2(DR_WIDTH + 1);
    localparam int RTI_W = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UIR   = 3'd1;
    localparam logic [2:0] S_CDR   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_UDR   = 3'd4;
    localparam logic [2:0] S_RTI   = 3'd5;
    localparam logic [2:0] S_RESP  = 3'd6;

    logic [2:0]          r_state;
    logic [DIV_W-1:0]    r_div;
    logic                r_tck;
    logic                r_tdi;
    logic [IR_WIDTH-1:0] r_ir_in;
    logic [DR_WIDTH-1:0] r_shift;
    logic [DR_WIDTH-1:0] r_cap;
    logic [BIT_W-1:0]    r_bits;
    logic [RTI_W-1:0]    r_rti;
    logic                r_rsp_valid;
    logic [DR_WIDTH-1:0] r_rsp_data;

    logic w_active;
    logic w_tick;
    logic w_rise;
    logic w_fall;
    logic w_skip_uir;

    assign w_active = (r_state != S_IDLE) && (r_state != S_RESP);
    assign w_tick   = w_active && (r_div == DIV_W'(TCK_DIV - 1));
    assign w_rise   = w_tick && !r_tck;
    assign w_fall   = w_tick && r_tck;

`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
    // r_ir_in already holds the last IR loaded by a UIR; the flag says it is meaningful.
    logic r_ir_vld;
    assign w_skip_uir = r_ir_vld && (bus.cmd_ir == r_ir_in);
`else
    assign w_skip_uir = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_tck       <= 1'b0;
            r_tdi       <= 1'b0;
            r_ir_in     <= '0;
            r_shift     <= '0;
            r_cap       <= '0;
            r_bits      <= '0;
            r_rti       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
            r_ir_vld    <= 1'b0;
`endif
        end else begin
            // Divider is parked at the start of a low phase whenever no scan is running.
            if (w_active) begin
                if (w_tick) begin
                    r_div <= '0;
                    r_tck <= ~r_tck;
                end else begin
                    r_div <= r_div + DIV_W'(1);
                end
            end else begin
                r_div <= '0;
                r_tck <= 1'b0;
            end

            if (w_rise && (r_state == S_SHIFT))
                r_cap <= {bus.vji_tdo, r_cap[DR_WIDTH-1:1]};

            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_shift <= bus.cmd_dr;
                        r_cap   <= '0;
                        r_bits  <= '0;
                        r_rti   <= '0;
                        if (w_skip_uir) begin
                            r_state <= S_CDR;
                        end else begin
                            r_state <= S_UIR;
                            r_ir_in <= bus.cmd_ir;
`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
                            r_ir_vld <= 1'b1;
`endif
                        end
                    end
                end
                S_UIR: if (w_fall) r_state <= S_CDR;
                S_CDR: begin
                    if (w_fall) begin
                        r_state <= S_SHIFT;
                        r_tdi   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_bits  <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        if (r_bits == BIT_W'(DR_WIDTH - 1)) begin
                            r_state <= S_UDR;
                            r_tdi   <= 1'b0;
                        end else begin
                            r_bits  <= r_bits + BIT_W'(1);
                            r_tdi   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end
                S_UDR: begin
                    if (w_fall) begin
                        r_state <= S_RTI;
                        r_rti   <= '0;
                    end
                end
                S_RTI: begin
                    if (w_fall) begin
                        if (r_rti == RTI_W'(RTI_CYCLES - 1))
                            r_state <= S_RESP;
                        else
                            r_rti <= r_rti + RTI_W'(1);
                    end
                end
                S_RESP: begin
                    // First RESP clk publishes the capture; rsp_valid then holds until consumed.
                    if (!r_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_cap;
                    end else if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.vji_tck   = r_tck;
    assign bus.vji_tdi   = r_tdi;
    assign bus.vji_ir_in = r_ir_in;
    assign bus.vji_uir   = (r_state == S_UIR);
    assign bus.vji_cdr   = (r_state == S_CDR);
    assign bus.vji_sdr   = (r_state == S_SHIFT);
    assign bus.vji_udr   = (r_state == S_UDR);
    assign bus.vji_rti   = (r_state == S_RTI);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_nios2_jtag_debug_scan_master.sv
// Bench for nios2_jtag_debug_scan_master: vector table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_nios2_jtag_debug_scan_master;
  localparam int DR = 38;
  localparam int IR = 2;

`ifdef NIOS2_JTAG_SCAN_IR_CACHE_EN
  localparam int REPEAT_LAT = 165;
  localparam int REPEAT_UIR = 0;
`else
  localparam int REPEAT_LAT = 169;
  localparam int REPEAT_UIR = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nios2_jtag_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus ();
  nios2_jtag_debug_scan_master_if #(.DR_WIDTH(DR), .IR_WIDTH(IR)) bus1 ();

  nios2_jtag_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(2), .RTI_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  nios2_jtag_debug_scan_master #(.DR_WIDTH(DR), .IR_WIDTH(IR), .TCK_DIV(1), .RTI_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // ---------------- scoreboard / counters ----------------
  logic [DR-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int acc_cyc = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- TAP-side model / monitor ----------------
  logic [DR-1:0] tdo_pat = '0;
  logic [DR-1:0] tdi_bits = '0;
  logic [IR-1:0] ir_seen = '0;
  int n_tdi = 0;
  int n_uir = 0;
  logic prev_tck = 1'b0;

  assign bus.vji_tdo  = (n_tdi < DR) ? tdo_pat[n_tdi] : 1'b0;
  assign bus1.vji_tdo = 1'b1;

  always @(negedge clk) begin
    int s;
    if (reset || bus.cmd_ready) begin
      n_tdi = 0;
      n_uir = 0;
      tdi_bits = '0;
    end else if (bus.vji_tck && !prev_tck) begin
      if (bus.vji_sdr) begin
        if (n_tdi < DR) tdi_bits[n_tdi] = bus.vji_tdi;
        n_tdi++;
      end
      if (bus.vji_uir) begin
        n_uir++;
        ir_seen = bus.vji_ir_in;
      end
    end
    prev_tck = bus.vji_tck;
    s = int'(bus.vji_uir) + int'(bus.vji_cdr) + int'(bus.vji_sdr) + int'(bus.vji_udr) + int'(bus.vji_rti);
    if (!reset && s != 0) check("strobe_onehot", s, 1);
  end

  // ---------------- driver tasks ----------------
  logic [IR-1:0] nxt_ir;
  logic [DR-1:0] nxt_dr, nxt_pat;

  task automatic issue(input logic [IR-1:0] ir, input logic [DR-1:0] dr,
                       input logic [DR-1:0] pat, input logic [DR-1:0] exp);
    int w = 0;
    logic [63:0] junk;
    while (!bus.cmd_ready && w < 50) begin @(negedge clk); w++; end
    check("cmd_ready_before_issue", bus.cmd_ready, 1);
    tdo_pat = pat;
    bus.cmd_ir = ir;
    bus.cmd_dr = dr;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    bus.cmd_valid = 1'b0;
    junk = {$urandom, $urandom};
    bus.cmd_ir = ~ir;
    bus.cmd_dr = junk[DR-1:0];
    exp_q.push_back(exp);
    check("accepted_busy", bus.cmd_ready, 0);
  endtask

  task automatic collect(input int hold, input int exp_lat, input logic [DR-1:0] exp_dr,
                         input logic [IR-1:0] exp_ir, input int exp_uir, input bit chain);
    int waited = 0;
    logic [DR-1:0] got, exp;
    while (!bus.rsp_valid && waited < 400) begin @(negedge clk); waited++; end
    if (!bus.rsp_valid) begin
      check("rsp_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    check("latency", cyc - acc_cyc, exp_lat);
    check("tdi_bit_count", n_tdi, DR);
    check("tdi_stream", tdi_bits, exp_dr);
    check("uir_pulses", n_uir, exp_uir);
    if (exp_uir > 0) check("ir_in_during_uir", ir_seen, exp_ir);
    got = bus.rsp_data;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_data", bus.rsp_data, got);
      check("hold_cmd_ready", bus.cmd_ready, 0);
      check("hold_tck", bus.vji_tck, 0);
    end
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check("rsp_data", got, exp);
    end
    bus.rsp_ready = 1'b1;
    if (chain) begin
      tdo_pat = nxt_pat;
      bus.cmd_ir = nxt_ir;
      bus.cmd_dr = nxt_dr;
      bus.cmd_valid = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("idle_after_rsp", bus.cmd_ready, 1);
    check("rsp_valid_dropped", bus.rsp_valid, 0);
    if (chain) begin
      @(negedge clk);
      acc_cyc = cyc;
      bus.cmd_valid = 1'b0;
      exp_q.push_back(nxt_pat);
      check("chain_accepted", bus.cmd_ready, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [IR-1:0] ir;
    logic [DR-1:0] dr;
    logic [DR-1:0] pat;
    int            hold;
    logic [DR-1:0] exp_data;
    int            exp_uir;
    int            exp_lat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [DR-1:0] got1;
    vecs[0] = '{2'b01, 38'h2A_5A5A_5A5A, 38'h00_0000_0000, 0,  38'h00_0000_0000, 1, 169};
    vecs[1] = '{2'b10, 38'h01_2345_6789, 38'h15_0F0F_F0F0, 20, 38'h15_0F0F_F0F0, 1, 169};
    vecs[2] = '{2'b11, 38'h3F_FFFF_FFFF, 38'h20_0000_0001, 0,  38'h20_0000_0001, 1, 169};
    vecs[3] = '{2'b00, 38'h00_0000_0001, 38'h3F_FFFF_FFFF, 3,  38'h3F_FFFF_FFFF, 1, 169};

    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_dr = '0; bus.rsp_ready = 1'b0;
    bus1.cmd_valid = 1'b0; bus1.cmd_ir = '0; bus1.cmd_dr = '0; bus1.rsp_ready = 1'b0;
    nxt_ir = '0; nxt_dr = '0; nxt_pat = '0;

    // reset values
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_tck", bus.vji_tck, 0);
    check("rst_tdi", bus.vji_tdi, 0);
    check("rst_ir_in", bus.vji_ir_in, 0);
    check("rst_strobes", {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}, 0);

    // table-driven scans
    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].ir, vecs[i].dr, vecs[i].pat, vecs[i].exp_data);
      collect(vecs[i].hold, vecs[i].exp_lat, vecs[i].dr, vecs[i].ir, vecs[i].exp_uir, 1'b0);
    end

    // cmd_valid during SHIFT is ignored, not queued
    issue(2'b01, 38'h0A_BCDE_F012, 38'h12_3456_789A, 38'h12_3456_789A);
    seen = 0;
    while (!bus.vji_sdr && seen < 100) begin @(negedge clk); seen++; end
    check("reached_shift", bus.vji_sdr, 1);
    bus.cmd_ir = 2'b10;
    bus.cmd_dr = 38'h35_5555_5555;
    bus.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.cmd_valid = 1'b0;
    collect(0, 169, 38'h0A_BCDE_F012, 2'b01, 1, 1'b0);
    seen = 0;
    repeat (20) begin @(negedge clk); if (!bus.cmd_ready || bus.rsp_valid) seen++; end
    check("no_queued_cmd", seen, 0);

    // reset in the middle of SHIFT
    issue(2'b11, 38'h1F_0000_FFFF, 38'h2A_AAAA_AAAA, 38'h2A_AAAA_AAAA);
    seen = 0;
    while (n_tdi < 10 && seen < 400) begin @(negedge clk); seen++; end
    check("reached_bit10", n_tdi >= 10, 1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_strobes", {bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr, bus.vji_rti}, 0);
    check("midrst_tck", bus.vji_tck, 0);
    check("midrst_tdi", bus.vji_tdi, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b0;
    exp_q.delete();
    seen = 0;
    repeat (200) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    check("no_rsp_after_reset", seen, 0);

    // repeated IR, issued back-to-back with the response handshake
    issue(2'b10, 38'h00_FFFF_0000, 38'h0C_3C3C_3C3C, 38'h0C_3C3C_3C3C);
    nxt_ir = 2'b10; nxt_dr = 38'h33_0F0F_1234; nxt_pat = 38'h05_A5A5_0F0F;
    collect(0, 169, 38'h00_FFFF_0000, 2'b10, 1, 1'b1);
    collect(0, REPEAT_LAT, 38'h33_0F0F_1234, 2'b10, REPEAT_UIR, 1'b0);

    // TCK_DIV=1 instance, tdo tied high
    @(negedge clk);
    check("div1_cmd_ready", bus1.cmd_ready, 1);
    bus1.cmd_ir = 2'b01;
    bus1.cmd_dr = 38'h2A_5A5A_5A5A;
    bus1.cmd_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc;
    bus1.cmd_valid = 1'b0;
    exp_q.push_back('1);
    seen = 0;
    while (!bus1.rsp_valid && seen < 300) begin @(negedge clk); seen++; end
    check("div1_rsp_valid", bus1.rsp_valid, 1);
    check("div1_latency", cyc - acc_cyc, 85);
    got1 = bus1.rsp_data;
    if (exp_q.size() > 0) check("div1_rsp_data", got1, exp_q.pop_front());
    else check("scoreboard_empty", 0, 1);
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    check("div1_idle", bus1.cmd_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
